slice_decode_sequencer: RTL and testbench
=========================================

# slice_decode_sequencer

Decoder-side slice controller for the ProRes pipeline. It accepts one slice-decode request and steps the DC variable-length decoder (VLD), the AC VLD, the byte-alignment flush and the inverse-quantiser/IDCT drain in order. Unlike the encoder-side free-running timing generator, it advances on per-coefficient handshakes from the VLD stages, so bitstream stalls are tolerated. It sits between the slice-header parser and the DC/AC VLD and IDCT stages.

## Interface
- COUNTER_WIDTH, 32: width of `sequence_counter`, `dc_vld_counter` and `ac_vld_counter`.
- MAX_BLOCKS, 32: largest supported `block_num`. Larger requests saturate to this value.
- IDCT_LATENCY, 10: fixed drain cycles added to `block_num` after the AC stage.

- clock  in  1: single clock; all logic is on the rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: one-cycle request to decode a slice. Ignored while `busy`.
- block_num  in  32: number of 8x8 blocks in the slice. Sampled only on an accepted `start`.
- dc_vld_done  in  1: DC VLD has produced one DC coefficient this cycle.
- ac_vld_done  in  1: AC VLD has produced one AC coefficient position this cycle.
- busy  out  1: a slice is in progress.
- sequence_counter  out  COUNTER_WIDTH: number of cycles since the accepted `start`.
- dc_vld_reset  out  1: active-low hold for the DC VLD. 0 = held in reset.
- dc_vld_enable  out  1: DC VLD may consume bits.
- dc_vld_counter  out  COUNTER_WIDTH: index of the DC coefficient currently being decoded.
- ac_vld_reset  out  1: active-low hold for the AC VLD.
- ac_vld_enable  out  1: AC VLD may consume bits.
- ac_vld_counter  out  COUNTER_WIDTH: index of the AC coefficient position currently being decoded.
- ac_vld_flush  out  1: one-cycle pulse telling the bit reader to discard padding up to the next byte boundary.
- idct_start  out  1: one-cycle pulse that starts the IDCT drain.
- slice_done  out  1: one-cycle pulse marking the end of the slice.

## Operation
- States: IDLE, DC_RST, DC_RUN, AC_RST, AC_RUN, DRAIN, DONE.
- Block count:
  - `N` = min(`block_num`, MAX_BLOCKS), latched on accept.
  - `ac_total` = 63*N, computed in 32 bits. With MAX_BLOCKS = 32 this cannot overflow.
- IDLE:
  - `start` with N > 0 goes to DC_RST.
  - `start` with N = 0 goes to DONE.
- DC_RST (1 cycle):
  - `dc_vld_reset` = 0, `dc_vld_counter` cleared.
  - Next state: DC_RUN.
- DC_RUN:
  - `dc_vld_reset` = 1, `dc_vld_enable` = 1.
  - Each `dc_vld_done` increments `dc_vld_counter`.
  - `dc_vld_done` while `dc_vld_counter` = N-1 goes to AC_RST. `dc_vld_enable` drops on that same edge.
- AC_RST (1 cycle):
  - `ac_vld_reset` = 0, `ac_vld_counter` cleared.
  - Next state: AC_RUN.
- AC_RUN:
  - `ac_vld_reset` = 1, `ac_vld_enable` = 1.
  - Each `ac_vld_done` increments `ac_vld_counter`.
  - `ac_vld_done` while `ac_vld_counter` = `ac_total`-1 goes to DRAIN.
- DRAIN:
  - Lasts exactly IDCT_LATENCY+N cycles, timed by an internal down-counter.
  - `ac_vld_flush` and `idct_start` pulse together in the first DRAIN cycle only.
  - Next state: DONE.
- DONE (1 cycle):
  - `slice_done` = 1.
  - On return to IDLE, `dc_vld_reset` and `ac_vld_reset` go back to 0.
- Counter holding:
  - Both VLD counters hold their final value until the next reset state.
  - A `*_vld_done` outside the matching RUN state is ignored.
- `sequence_counter`:
  - Loaded with 1 on the accepted-`start` edge, then +1 per cycle while `busy`. It therefore equals k in the cycle k after `start`.
  - Saturates at all-ones.
  - Holds its value in IDLE.

## Timing
- Reset: every output is 0, including both `*_vld_reset`, all counters and all pulses. State = IDLE.
- Reset asserted mid-slice: all outputs are at reset values in the next cycle, and any in-progress slice is abandoned with no `slice_done`.
- Cycle numbering: `start` is sampled at edge t.
- `busy` = 1 from cycle t+1 through the DONE cycle inclusive, and 0 in the cycle after DONE.
- DC stage:
  - DC_RST occupies cycle t+1.
  - The earliest `dc_vld_enable` is cycle t+2.
- Stall-free minimum slice length: 1 (DC_RST) + N + 1 (AC_RST) + 63N + IDCT_LATENCY + N + 1 (DONE) cycles.
- Handshake timing: `*_vld_done` is sampled on the same edge that updates the counter. Counter outputs are registered, never combinational.
- Stalls: any number of cycles without `*_vld_done` extends the RUN state. No timeout.
- `start` coincident with `slice_done`: ignored, because `busy` is still 1.
- `start` and `reset` in the same cycle: reset wins.

## Test plan
- Reset, then idle for 20 cycles:
  - All outputs stay 0 and `sequence_counter` = 0.
- `block_num`=4, IDCT_LATENCY=10, done inputs tied high, `start` at edge t:
  - `dc_vld_enable` high for t+2..t+5.
  - AC_RST at t+6.
  - `ac_vld_enable` high for t+7..t+258, with `ac_vld_counter` reaching 251.
  - `ac_vld_flush` and `idct_start` at t+259.
  - `slice_done` at t+273.
  - `busy` low at t+274.
- Same run, but `dc_vld_done` withheld for 5 cycles at index 2:
  - `slice_done` arrives at t+278.
  - `dc_vld_counter` holds 2 during the stall.
- `block_num`=0:
  - `slice_done` at t+1.
  - No VLD enable, reset release or flush ever asserted.
- `block_num`=100:
  - N saturates to 32, giving `ac_total` = 2016.
  - `slice_done` at t+1+32+1+2016+42+1.
- Disturbances during a 4-block slice:
  - Second `start` mid-slice: ignored.
  - `reset` in AC_RUN: all outputs 0 next cycle and no `slice_done`.
  - A subsequent `start` then decodes normally.

Source files
------------

// File: rtl/slice_decode_sequencer.sv
// Decoder-side slice controller: sequences DC VLD, AC VLD, byte-align flush and IDCT drain
// for one slice, advancing on per-coefficient handshakes so bitstream stalls are tolerated.
module slice_decode_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned MAX_BLOCKS    = 32,
    parameter int unsigned IDCT_LATENCY  = 10
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [31:0]              i_block_num,
    input  logic                     i_dc_vld_done,
    input  logic                     i_ac_vld_done,
    output logic                     o_busy,
    output logic [COUNTER_WIDTH-1:0] o_sequence_counter,
    output logic                     o_dc_vld_reset,
    output logic                     o_dc_vld_enable,
    output logic [COUNTER_WIDTH-1:0] o_dc_vld_counter,
    output logic                     o_ac_vld_reset,
    output logic                     o_ac_vld_enable,
    output logic [COUNTER_WIDTH-1:0] o_ac_vld_counter,
    output logic                     o_ac_vld_flush,
    output logic                     o_idct_start,
    output logic                     o_slice_done
);

    localparam int unsigned BLK_W = $clog2(MAX_BLOCKS + 1);
    localparam int unsigned DRN_W = $clog2(MAX_BLOCKS + IDCT_LATENCY + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DC_RST = 3'd1;
    localparam logic [2:0] S_DC_RUN = 3'd2;
    localparam logic [2:0] S_AC_RST = 3'd3;
    localparam logic [2:0] S_AC_RUN = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]               r_state,      w_state_nxt;
    logic [BLK_W-1:0]         r_blocks,     w_blocks_nxt;
    logic [31:0]              r_ac_total,   w_ac_total_nxt;
    logic [DRN_W-1:0]         r_drain,      w_drain_nxt;
    logic [COUNTER_WIDTH-1:0] r_seq,        w_seq_nxt;
    logic [COUNTER_WIDTH-1:0] r_dc_cnt,     w_dc_cnt_nxt;
    logic [COUNTER_WIDTH-1:0] r_ac_cnt,     w_ac_cnt_nxt;
    logic                     r_dc_rel,     w_dc_rel_nxt;
    logic                     r_ac_rel,     w_ac_rel_nxt;
    logic                     r_busy,       w_busy_nxt;
    logic                     r_dc_en,      w_dc_en_nxt;
    logic                     r_ac_en,      w_ac_en_nxt;
    logic                     r_flush,      w_flush_nxt;
    logic                     r_done,       w_done_nxt;

    logic [BLK_W-1:0]         w_block_sat;
    logic                     w_dc_last;
    logic                     w_ac_last;

    assign w_block_sat = (i_block_num > 32'(MAX_BLOCKS)) ? BLK_W'(MAX_BLOCKS)
                                                          : BLK_W'(i_block_num);
    assign w_dc_last   = i_dc_vld_done &&
                         (r_dc_cnt == COUNTER_WIDTH'(r_blocks - BLK_W'(1)));
    assign w_ac_last   = i_ac_vld_done &&
                         (r_ac_cnt == COUNTER_WIDTH'(r_ac_total - 32'd1));

    // Next state, counters and next-cycle output values; outputs are registered from these
    always_comb begin
        w_state_nxt    = r_state;
        w_blocks_nxt   = r_blocks;
        w_ac_total_nxt = r_ac_total;
        w_drain_nxt    = r_drain;
        w_seq_nxt      = r_seq;
        w_dc_cnt_nxt   = r_dc_cnt;
        w_ac_cnt_nxt   = r_ac_cnt;
        w_dc_rel_nxt   = r_dc_rel;
        w_ac_rel_nxt   = r_ac_rel;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_blocks_nxt   = w_block_sat;
                    w_ac_total_nxt = 32'(w_block_sat) * 32'd63;
                    w_seq_nxt      = COUNTER_WIDTH'(1);
                    if (w_block_sat != '0) begin
                        w_state_nxt  = S_DC_RST;
                        w_dc_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_DC_RST: begin
                w_state_nxt  = S_DC_RUN;
                w_dc_rel_nxt = 1'b1;
            end
            S_DC_RUN: begin
                if (i_dc_vld_done) begin
                    w_dc_cnt_nxt = r_dc_cnt + COUNTER_WIDTH'(1);
                end
                if (w_dc_last) begin
                    w_state_nxt  = S_AC_RST;
                    w_ac_cnt_nxt = '0;
                end
            end
            S_AC_RST: begin
                w_state_nxt  = S_AC_RUN;
                w_ac_rel_nxt = 1'b1;
            end
            S_AC_RUN: begin
                if (i_ac_vld_done) begin
                    w_ac_cnt_nxt = r_ac_cnt + COUNTER_WIDTH'(1);
                end
                if (w_ac_last) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRN_W'(IDCT_LATENCY) + DRN_W'(r_blocks) - DRN_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain - DRN_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt  = S_IDLE;
                w_dc_rel_nxt = 1'b0;
                w_ac_rel_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = S_IDLE;
            end
        endcase

        // Cycle count keeps running through DONE and freezes once back in IDLE
        if ((r_state != S_IDLE) && (w_state_nxt != S_IDLE) && (r_seq != '1)) begin
            w_seq_nxt = r_seq + COUNTER_WIDTH'(1);
        end

        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_dc_en_nxt = (w_state_nxt == S_DC_RUN);
        w_ac_en_nxt = (w_state_nxt == S_AC_RUN);
        w_flush_nxt = (w_state_nxt == S_DRAIN) && (r_state != S_DRAIN);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_blocks   <= '0;
            r_ac_total <= '0;
            r_drain    <= '0;
            r_seq      <= '0;
            r_dc_cnt   <= '0;
            r_ac_cnt   <= '0;
            r_dc_rel   <= 1'b0;
            r_ac_rel   <= 1'b0;
            r_busy     <= 1'b0;
            r_dc_en    <= 1'b0;
            r_ac_en    <= 1'b0;
            r_flush    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_blocks   <= w_blocks_nxt;
            r_ac_total <= w_ac_total_nxt;
            r_drain    <= w_drain_nxt;
            r_seq      <= w_seq_nxt;
            r_dc_cnt   <= w_dc_cnt_nxt;
            r_ac_cnt   <= w_ac_cnt_nxt;
            r_dc_rel   <= w_dc_rel_nxt;
            r_ac_rel   <= w_ac_rel_nxt;
            r_busy     <= w_busy_nxt;
            r_dc_en    <= w_dc_en_nxt;
            r_ac_en    <= w_ac_en_nxt;
            r_flush    <= w_flush_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_busy             = r_busy;
    assign o_sequence_counter = r_seq;
    assign o_dc_vld_reset     = r_dc_rel;
    assign o_dc_vld_enable    = r_dc_en;
    assign o_dc_vld_counter   = r_dc_cnt;
    assign o_ac_vld_reset     = r_ac_rel;
    assign o_ac_vld_enable    = r_ac_en;
    assign o_ac_vld_counter   = r_ac_cnt;
    assign o_ac_vld_flush     = r_flush;
    assign o_idct_start       = r_flush;
    assign o_slice_done       = r_done;

endmodule

// File: tb/tb_slice_decode_sequencer.sv
// Bench for slice_decode_sequencer: a timeline model derives phase boundaries from
// handshake counts and predicts every output cycle by cycle.
module tb_slice_decode_sequencer;

    localparam int CW   = 32;
    localparam int MAXB = 32;
    localparam int IDCT = 10;
    localparam int INF  = 1 << 30;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [31:0]   i_block_num;
    logic          i_dc_vld_done;
    logic          i_ac_vld_done;
    logic          o_busy;
    logic [CW-1:0] o_sequence_counter;
    logic          o_dc_vld_reset;
    logic          o_dc_vld_enable;
    logic [CW-1:0] o_dc_vld_counter;
    logic          o_ac_vld_reset;
    logic          o_ac_vld_enable;
    logic [CW-1:0] o_ac_vld_counter;
    logic          o_ac_vld_flush;
    logic          o_idct_start;
    logic          o_slice_done;

    int checks = 0;
    int errors = 0;
    int m_dc_hold = 0;
    int m_ac_hold = 0;

    always #5 clk = ~clk;

    slice_decode_sequencer #(
        .COUNTER_WIDTH (CW),
        .MAX_BLOCKS    (MAXB),
        .IDCT_LATENCY  (IDCT)
    ) dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_block_num        (i_block_num),
        .i_dc_vld_done      (i_dc_vld_done),
        .i_ac_vld_done      (i_ac_vld_done),
        .o_busy             (o_busy),
        .o_sequence_counter (o_sequence_counter),
        .o_dc_vld_reset     (o_dc_vld_reset),
        .o_dc_vld_enable    (o_dc_vld_enable),
        .o_dc_vld_counter   (o_dc_vld_counter),
        .o_ac_vld_reset     (o_ac_vld_reset),
        .o_ac_vld_enable    (o_ac_vld_enable),
        .o_ac_vld_counter   (o_ac_vld_counter),
        .o_ac_vld_flush     (o_ac_vld_flush),
        .o_idct_start       (o_idct_start),
        .o_slice_done       (o_slice_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one slice and checks every output each cycle; cycle c is the c-th cycle after start
    task automatic run_slice(input int bn, input int pdc, input int pac, input int st_idx,
                             input int st_len, input bit noise, output int done_c);
        int n, act, c_dc_end, c_ac_end, c_done, dc_cnt, ac_cnt, st_left;
        int exp_seq, exp_dc, exp_ac;
        bit dcb, acb, fin;
        logic [7:0] exp_f, got_f;
        n        = (bn > MAXB) ? MAXB : bn;
        act      = 63 * n;
        c_dc_end = INF;
        c_ac_end = INF;
        c_done   = (n == 0) ? 1 : INF;
        dc_cnt   = 0;
        ac_cnt   = 0;
        st_left  = st_len;
        done_c   = -1;
        fin      = 1'b0;
        i_block_num = 32'(bn);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 20000; c++) begin
            exp_f = {c <= c_done,
                     n > 0 && c >= 2 && c <= c_done,
                     n > 0 && c >= 2 && c <= c_dc_end,
                     c_dc_end != INF && c >= c_dc_end + 2 && c <= c_done,
                     c_dc_end != INF && c >= c_dc_end + 2 && c <= c_ac_end,
                     c == c_ac_end + 1,
                     c == c_ac_end + 1,
                     c == c_done};
            got_f = {o_busy, o_dc_vld_reset, o_dc_vld_enable, o_ac_vld_reset,
                     o_ac_vld_enable, o_ac_vld_flush, o_idct_start, o_slice_done};
            exp_seq = (c <= c_done) ? c : c_done;
            exp_dc  = (n > 0) ? dc_cnt : m_dc_hold;
            exp_ac  = (c_dc_end != INF && c >= c_dc_end + 1) ? ac_cnt : m_ac_hold;
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL flags n=%0d cycle %0d: got %b expected %b (busy,dcrst,dcen,acrst,acen,flush,idct,done)",
                         bn, c, got_f, exp_f);
            end
            checks++;
            if (o_sequence_counter !== 32'(exp_seq)) begin
                errors++;
                $display("FAIL seq_counter n=%0d cycle %0d: got %0d expected %0d", bn, c, o_sequence_counter, exp_seq);
            end
            checks++;
            if (o_dc_vld_counter !== 32'(exp_dc)) begin
                errors++;
                $display("FAIL dc_counter n=%0d cycle %0d: got %0d expected %0d", bn, c, o_dc_vld_counter, exp_dc);
            end
            checks++;
            if (o_ac_vld_counter !== 32'(exp_ac)) begin
                errors++;
                $display("FAIL ac_counter n=%0d cycle %0d: got %0d expected %0d", bn, c, o_ac_vld_counter, exp_ac);
            end
            if (o_slice_done === 1'b1 && done_c < 0) done_c = c;
            if (c == c_done + 1) begin
                fin = 1'b1;
                i_start = 1'b0;
                break;
            end
            dcb = ($urandom_range(99) < pdc);
            acb = ($urandom_range(99) < pac);
            if (n > 0 && c >= 2 && c <= c_dc_end && dc_cnt == st_idx && st_left > 0) begin
                dcb = 1'b0;
                st_left--;
            end
            i_dc_vld_done = dcb;
            i_ac_vld_done = acb;
            if (noise) begin
                i_start     = (c == c_done) || ($urandom_range(3) == 0);
                i_block_num = $urandom;
            end
            if (n > 0 && c >= 2 && c_dc_end == INF && dcb) begin
                dc_cnt++;
                if (dc_cnt == n) c_dc_end = c;
            end
            if (c_dc_end != INF && c >= c_dc_end + 2 && c_ac_end == INF && acb) begin
                ac_cnt++;
                if (ac_cnt == act) begin
                    c_ac_end = c;
                    c_done   = c + IDCT + n + 1;
                end
            end
            tick();
        end
        i_start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL slice_timeout n=%0d: got no completion expected completion within bound", bn);
        end
        if (n > 0) begin
            m_dc_hold = n;
            m_ac_hold = act;
        end
    endtask

    task automatic test_reset();
        logic [103:0] got;
        i_reset = 1'b1; i_start = 1'b0; i_block_num = 32'd4;
        i_dc_vld_done = 1'b0; i_ac_vld_done = 1'b0;
        tick(); tick();
        i_start = 1'b1;
        tick();
        i_reset = 1'b0; i_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            got = {o_busy, o_dc_vld_reset, o_dc_vld_enable, o_ac_vld_reset, o_ac_vld_enable,
                   o_ac_vld_flush, o_idct_start, o_slice_done,
                   o_sequence_counter, o_dc_vld_counter, o_ac_vld_counter};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected 0", k, got);
            end
            tick();
        end
        m_dc_hold = 0;
        m_ac_hold = 0;
    endtask

    task automatic test_tied_high();
        int d;
        run_slice(4, 100, 100, -1, 0, 1'b0, d);
        checks++;
        if (d !== 273) begin
            errors++;
            $display("FAIL tied_high_done_cycle: got %0d expected 273", d);
        end
    endtask

    task automatic test_dc_stall();
        int d;
        run_slice(4, 100, 100, 2, 5, 1'b0, d);
        checks++;
        if (d !== 278) begin
            errors++;
            $display("FAIL dc_stall_done_cycle: got %0d expected 278", d);
        end
    endtask

    task automatic test_zero_blocks();
        int d;
        run_slice(0, 100, 100, -1, 0, 1'b0, d);
        checks++;
        if (d !== 1) begin
            errors++;
            $display("FAIL zero_blocks_done_cycle: got %0d expected 1", d);
        end
    endtask

    task automatic test_saturation();
        int d;
        run_slice(100, 100, 100, -1, 0, 1'b0, d);
        checks++;
        if (d !== 1 + 32 + 1 + 2016 + 42 + 1) begin
            errors++;
            $display("FAIL saturation_done_cycle: got %0d expected %0d", d, 1 + 32 + 1 + 2016 + 42 + 1);
        end
    endtask

    task automatic test_random_stalls();
        int d;
        for (int k = 0; k < 6; k++) begin
            run_slice(int'($urandom_range(1, 12)), int'($urandom_range(30, 100)),
                      int'($urandom_range(60, 100)), -1, 0, 1'b0, d);
        end
    endtask

    task automatic test_start_noise();
        int d;
        run_slice(4, 70, 80, -1, 0, 1'b1, d);
    endtask

    task automatic test_back_to_back();
        int d;
        run_slice(3, 100, 100, -1, 0, 1'b0, d);
        run_slice(0, 50, 50, -1, 0, 1'b0, d);
        run_slice(2, 60, 90, -1, 0, 1'b0, d);
    endtask

    task automatic test_reset_mid_slice();
        logic [103:0] got;
        int d;
        i_block_num = 32'd4; i_dc_vld_done = 1'b1; i_ac_vld_done = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        checks++;
        if (o_ac_vld_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_in_ac_run: got ac_enable %b expected 1", o_ac_vld_enable);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        got = {o_busy, o_dc_vld_reset, o_dc_vld_enable, o_ac_vld_reset, o_ac_vld_enable,
               o_ac_vld_flush, o_idct_start, o_slice_done,
               o_sequence_counter, o_dc_vld_counter, o_ac_vld_counter};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0", got);
        end
        for (int k = 0; k < 300; k++) begin
            checks++;
            if (o_slice_done !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_done cycle %0d: got done=%b busy=%b expected 0 0", k, o_slice_done, o_busy);
            end
            tick();
        end
        m_dc_hold = 0;
        m_ac_hold = 0;
        run_slice(4, 100, 100, -1, 0, 1'b0, d);
        checks++;
        if (d !== 273) begin
            errors++;
            $display("FAIL after_reset_done_cycle: got %0d expected 273", d);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_block_num = '0;
        i_dc_vld_done = 1'b0; i_ac_vld_done = 1'b0;
        test_reset();
        test_tied_high();
        test_dc_stall();
        test_zero_blocks();
        test_saturation();
        test_random_stalls();
        test_start_noise();
        test_back_to_back();
        test_reset_mid_slice();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
